// File: rtl/sd_block_buf_ctrl.sv
// sd_block_buf_ctrl: ping-pong block buffer between the SD card data stream
// and a host-side consumer. Two banks of 2^SIZE words are filled and drained
// alternately, in fill order, with back-pressure when both are occupied.
module sd_block_buf_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SIZE       = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  abort,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_dv,
    output logic                  out_last,
    output logic                  blk_ready,
    output logic [15:0]           blk_count,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 2 ** SIZE;
    localparam logic [SIZE-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    bank_state_t           bank_st [2];
    logic                  wbank;
    logic                  rbank;
    logic [SIZE-1:0]       waddr;
    logic [SIZE-1:0]       raddr;
    logic [DATA_WIDTH-1:0] mem [2*DEPTH];

    logic wr_acc;
    logic rd_acc;
    logic abort_fill;

    // Handshake qualifiers; abort always suppresses a same-cycle write.
    assign in_ready   = (bank_st[wbank] == EMPTY) || (bank_st[wbank] == FILLING);
    assign blk_ready  = (bank_st[rbank] == FULL)  || (bank_st[rbank] == DRAINING);
    assign abort_fill = abort && (bank_st[wbank] == FILLING);
    assign wr_acc     = in_valid && in_ready && !abort;
    assign rd_acc     = rd && blk_ready;

    // Bank storage: {bank, addr} addressing, contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[{wbank, waddr}] <= in_data;
        end
    end

    // Bank state machines, pointers, read port and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            waddr      <= '0;
            raddr      <= '0;
            out_data   <= '0;
            out_dv     <= 1'b0;
            out_last   <= 1'b0;
            blk_count  <= 16'd0;
            overflow   <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_acc && (wbank == 1'(b))) begin
                    bank_st[b] <= (waddr == LAST_ADDR) ? FULL : FILLING;
                end else if (abort_fill && (wbank == 1'(b))) begin
                    bank_st[b] <= EMPTY;
                end else if (rd_acc && (rbank == 1'(b))) begin
                    bank_st[b] <= (raddr == LAST_ADDR) ? EMPTY : DRAINING;
                end
            end

            if (abort_fill) begin
                waddr <= '0;
            end else if (wr_acc) begin
                waddr <= waddr + SIZE'(1);
                if (waddr == LAST_ADDR) begin
                    wbank <= ~wbank;
                end
            end

            if (in_valid && !in_ready && !abort) begin
                overflow <= 1'b1;
            end

            out_dv   <= rd_acc;
            out_last <= rd_acc && (raddr == LAST_ADDR);
            if (rd_acc) begin
                out_data <= mem[{rbank, raddr}];
                raddr    <= raddr + SIZE'(1);
                if (raddr == LAST_ADDR) begin
                    rbank     <= ~rbank;
                    blk_count <= blk_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_block_buf_ctrl.sv
// Directed testbench for sd_block_buf_ctrl with 4-word blocks.
`timescale 1ns/1ps
module tb_sd_block_buf_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned SZ = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          abort;
    logic          rd;
    logic [DW-1:0] out_data;
    logic          out_dv;
    logic          out_last;
    logic          blk_ready;
    logic [15:0]   blk_count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    sd_block_buf_ctrl #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .abort     (abort),
        .rd        (rd),
        .out_data  (out_data),
        .out_dv    (out_dv),
        .out_last  (out_last),
        .blk_ready (blk_ready),
        .blk_count (blk_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for one cycle.
    task automatic put(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Pop one word and check what comes back one cycle later.
    task automatic pop(input string tag, input logic [7:0] d, input logic last);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check({tag, "_dv"},   32'(out_dv),   32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_last"}, 32'(out_last), 32'(last));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        abort    = 1'b0;
        rd       = 1'b0;
        do_reset();

        // Reset values
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_blk_ready", 32'(blk_ready), 32'd0);
        check("rst_out_dv",    32'(out_dv),    32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_blk_count", 32'(blk_count), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);

        // 1: single block round trip
        put(8'h10); put(8'h11); put(8'h12);
        check("t1_not_ready_yet", 32'(blk_ready), 32'd0);
        put(8'h13);
        check("t1_blk_ready", 32'(blk_ready), 32'd1);
        check("t1_in_ready",  32'(in_ready),  32'd1);
        pop("t1_w0", 8'h10, 1'b0);
        pop("t1_w1", 8'h11, 1'b0);
        pop("t1_w2", 8'h12, 1'b0);
        check("t1_cnt_before_last", 32'(blk_count), 32'd0);
        pop("t1_w3", 8'h13, 1'b1);
        check("t1_blk_count", 32'(blk_count), 32'd1);
        check("t1_blk_ready_low", 32'(blk_ready), 32'd0);
        tick();
        check("t1_dv_pulse", 32'(out_dv), 32'd0);

        // 2: both banks full, extra words dropped (bank 1 then bank 0)
        for (int i = 0; i < 12; i++) begin
            put(8'(i));
            if (i == 6) check("t2_ready_w6", 32'(in_ready), 32'd1);
            if (i == 7) check("t2_ready_w7", 32'(in_ready), 32'd0);
        end
        check("t2_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop("t2_rd", 8'(i), (i == 3) || (i == 7));
        end
        check("t2_blk_count", 32'(blk_count), 32'd3);
        check("t2_in_ready",  32'(in_ready),  32'd1);

        // 3: concurrent drain of bank 0 and fill of bank 1
        do_reset();
        put(8'h30); put(8'h31); put(8'h32); put(8'h33);
        for (int i = 0; i < 4; i++) begin
            check("t3_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = 8'h20 + 8'(i);
            rd       = 1'b1;
            tick();
            in_valid = 1'b0;
            rd       = 1'b0;
            check("t3_dv",   32'(out_dv),   32'd1);
            check("t3_data", 32'(out_data), 32'h30 + 32'(i));
        end
        check("t3_cnt1",      32'(blk_count), 32'd1);
        check("t3_blk_ready", 32'(blk_ready), 32'd1);
        pop("t3_b0", 8'h20, 1'b0);
        pop("t3_b1", 8'h21, 1'b0);
        pop("t3_b2", 8'h22, 1'b0);
        pop("t3_b3", 8'h23, 1'b1);
        check("t3_cnt2",     32'(blk_count), 32'd2);
        check("t3_overflow", 32'(overflow),  32'd0);

        // 4: abort a partial block, including an abort with a same-cycle write
        put(8'h55); put(8'h56);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_ready", 32'(blk_ready), 32'd0);
        put(8'h57);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        put(8'hA0); put(8'hA1); put(8'hA2); put(8'hA3);
        check("t4_blk_ready", 32'(blk_ready), 32'd1);
        pop("t4_r0", 8'hA0, 1'b0);
        pop("t4_r1", 8'hA1, 1'b0);
        pop("t4_r2", 8'hA2, 1'b0);
        pop("t4_r3", 8'hA3, 1'b1);
        check("t4_overflow", 32'(overflow),  32'd0);
        check("t4_cnt",      32'(blk_count), 32'd3);

        // 5: rd with no block present is ignored
        rd = 1'b1;
        tick();
        check("t5_dv0", 32'(out_dv), 32'd0);
        tick();
        rd = 1'b0;
        check("t5_dv1",  32'(out_dv),    32'd0);
        check("t5_cnt",  32'(blk_count), 32'd3);
        check("t5_last", 32'(out_last),  32'd0);
        put(8'hC0); put(8'hC1); put(8'hC2); put(8'hC3);
        pop("t5_r0", 8'hC0, 1'b0);
        pop("t5_r1", 8'hC1, 1'b0);
        pop("t5_r2", 8'hC2, 1'b0);
        pop("t5_r3", 8'hC3, 1'b1);
        check("t5_cnt2", 32'(blk_count), 32'd4);

        // 6: reset mid-drain clears outputs asynchronously
        put(8'hD0); put(8'hD1); put(8'hD2); put(8'hD3);
        pop("t6_r0", 8'hD0, 1'b0);
        pop("t6_r1", 8'hD1, 1'b0);
        rd = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_dv",        32'(out_dv),    32'd0);
        check("t6_rst_data",      32'(out_data),  32'd0);
        check("t6_rst_blk_ready", 32'(blk_ready), 32'd0);
        check("t6_rst_in_ready",  32'(in_ready),  32'd1);
        check("t6_rst_cnt",       32'(blk_count), 32'd0);
        rd = 1'b0;
        tick();
        reset = 1'b0;
        put(8'hE0); put(8'hE1); put(8'hE2); put(8'hE3);
        pop("t6_r0b", 8'hE0, 1'b0);
        pop("t6_r1b", 8'hE1, 1'b0);
        pop("t6_r2b", 8'hE2, 1'b0);
        pop("t6_r3b", 8'hE3, 1'b1);
        check("t6_cnt", 32'(blk_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_block_buf_ctrl.md
# sd_block_buf_ctrl

Ping-pong block buffer controller between the SD card data path and the host-side consumer. It owns two internal block banks of 2^SIZE words each. It steers the incoming card byte stream into whichever bank is free, and hands completed blocks to the consumer in the order they were filled. It also applies back-pressure to the card side when both banks are occupied.

## Interface
Parameters:
- DATA_WIDTH, 8, word width of the card stream and of each bank entry.
- SIZE, 9, log2 of the block length in words (default 512-word block).

Ports:
- clk, in, 1, single clock; all logic is rising-edge.
- reset, in, 1, asynchronous, active-high; clears all state immediately.
- in_valid, in, 1, card-side word strobe.
- in_data, in, DATA_WIDTH, card-side word.
- in_ready, out, 1, write bank can accept a word this cycle.
- abort, in, 1, synchronous; discards the partially filled bank.
- rd, in, 1, consumer pop request.
- out_data, out, DATA_WIDTH, read word, registered.
- out_dv, out, 1, out_data valid (one-cycle pulse per accepted rd).
- out_last, out, 1, high with out_dv on the final word of a block.
- blk_ready, out, 1, read bank holds a complete block not yet fully drained.
- blk_count, out, 16, number of blocks fully drained since reset; wraps at 65535 -> 0.
- overflow, out, 1, sticky; a word was offered while in_ready=0.

## Operation
- Per-bank state: EMPTY, FILLING, FULL, DRAINING.
- Per-bank transitions:
  - EMPTY -> FILLING on the first accepted write.
  - FILLING -> FULL on the accepted write at address 2^SIZE-1.
  - FULL -> DRAINING on the first accepted rd.
  - DRAINING -> EMPTY on the accepted rd at address 2^SIZE-1.
- Write pointer: wbank (1 bit) and waddr (SIZE bits).
  - A write is accepted when in_valid & in_ready.
  - On acceptance, the word is stored at bank[wbank][waddr] and waddr increments.
  - When waddr wraps to 0, wbank toggles.
- Read pointer: rbank and raddr.
  - A rd is accepted when rd & blk_ready.
  - On acceptance, raddr increments.
  - When raddr wraps to 0, rbank toggles and blk_count increments.
- Combinational outputs:
  - in_ready = state[wbank] is EMPTY or FILLING.
  - blk_ready = state[rbank] is FULL or DRAINING.
- Blocks are drained strictly in fill order. Bank 0 is filled first after reset.
- A rd while blk_ready=0 is ignored: no out_dv, no state change.
- A write offered while in_ready=0 is dropped and sets overflow. overflow is cleared only by reset.
- Simultaneous write (to wbank) and read (from rbank, the other bank) are both serviced in the same cycle.
- When wbank == rbank, only one side can be active, which the state rules enforce.
- abort:
  - If state[wbank] is FILLING, that bank becomes EMPTY and waddr returns to 0; wbank is unchanged.
  - abort has no effect on FULL or DRAINING banks.
  - abort wins over a same-cycle write, which is discarded without setting overflow.

## Timing
- Reset values: all banks EMPTY, all pointers 0, out_data=0, out_dv=0, out_last=0, blk_count=0, overflow=0. As a result, in_ready=1 and blk_ready=0.
- Read latency is 1 cycle: a rd accepted in cycle N gives out_data/out_dv in cycle N+1.
- out_last is asserted with the out_dv of the raddr=2^SIZE-1 word.
- Back-to-back rd every cycle yields one word per cycle.
- State updates are registered:
  - The bank completed in cycle N reads as FULL in N+1, so blk_ready rises in N+1.
  - The bank drained in cycle N reads as EMPTY in N+1.
  - If the writer is stalled on that bank, in_ready rises in N+1.
- blk_count updates in the cycle after the last rd. It becomes visible together with out_last.
- Reset asserted mid-block discards all stored data immediately, including any pending out_dv.
- Memory contents need no reset.

## Test plan
Run with SIZE=2 (4-word blocks), DATA_WIDTH=8.

1. Reset, then write 0x10..0x13 -> blk_ready=1 the cycle after the 4th write. Next, 4 rd cycles -> out_dv on 4 consecutive cycles with out_data 0x10..0x13, out_last on 0x13, and blk_count=1.
2. Write 12 words 0x00..0x0B with no reads -> in_ready drops after word 0x07. Words 0x08..0x0B are dropped and overflow=1. Draining then returns 0x00..0x07 in order.
3. With bank 0 FULL, read bank 0 while concurrently writing 0x20..0x23 into bank 1 -> both complete with no stall. A second drain returns 0x20..0x23.
4. Write 2 words, assert abort, then write 0xA0..0xA3 -> the block read back is 0xA0..0xA3 and overflow=0.
5. Assert rd with no block present -> no out_dv, and pointers are unchanged.
6. Assert reset mid-drain after 2 of 4 reads -> all outputs return to their reset values in the same cycle. A subsequent fresh block reads correctly from bank 0.
